// File: rtl/mitll_jtl_pkg.sv
// Shared limits, defaults and width helper for the JTL delay-line array.
package mitll_jtl_pkg;

  localparam int CHANNELS_MIN = 1;
  localparam int CHANNELS_MAX = 32;
  localparam int DEPTH_MIN    = 2;
  localparam int DEPTH_MAX    = 64;

  localparam int DEF_CHANNELS = 4;
  localparam int DEF_DEPTH    = 8;
  localparam int DEF_CNT_W    = 16;

  // Bits needed to index n values, never less than one.
  function automatic int width_of(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mitll_jtl_lane.sv
// One JTL delay lane: pulse pipeline, programmable delay, flush and busy.
// A pulse with delay D is written into stage D-2 and shifts down to stage 0;
// the output register is the final stage, so D=1 bypasses the pipeline.
module mitll_jtl_lane
  import mitll_jtl_pkg::*;
#(
  parameter int DEPTH     = DEF_DEPTH,
  parameter int DEF_DELAY = DEPTH,
  parameter int DW        = width_of(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_i,
  input  logic          flush_i,
  input  logic [DW-1:0] delay_i,
  output logic          out_o,
  output logic          busy_o,
  output logic [DW-1:0] drop_o
);

  logic [DEPTH-2:0] stage_q, stage_d;
  logic [DW-1:0]    delay_q, delay_d;
  logic             out_q, out_d;
  logic             busy_q;

  // Next pipeline state; a flush clears the lane but the pulse in stage 0
  // still leaves on the output, and a new pulse uses the new delay.
  always_comb begin
    delay_d = flush_i ? delay_i : delay_q;
    stage_d = flush_i ? '0 : (stage_q >> 1);
    for (int i = 0; i < DEPTH - 1; i++) begin
      if (in_i && (delay_d == DW'(i + 2))) stage_d[i] = 1'b1;
    end
    out_d = stage_q[0] | (in_i && (delay_d == DW'(1)));
  end

  // Pulses that a flush would discard: everything except the one leaving now.
  always_comb begin
    drop_o = '0;
    for (int i = 1; i < DEPTH - 1; i++) begin
      drop_o = drop_o + DW'(stage_q[i]);
    end
  end

  // Lane registers with synchronous reset to the default delay.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= '0;
      delay_q <= DW'(DEF_DELAY);
      out_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      stage_q <= stage_d;
      delay_q <= delay_d;
      out_q   <= out_d;
      busy_q  <= |stage_d;
    end
  end

  assign out_o  = out_q;
  assign busy_o = busy_q;

endmodule

// File: rtl/mitll_jtl_array.sv
// Multi-lane clocked JTL delay-line array with per-lane delay writes,
// flush-on-write, rejected-write flag and saturating drop counter.
module mitll_jtl_array
  import mitll_jtl_pkg::*;
#(
  parameter int CHANNELS  = DEF_CHANNELS,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int DEF_DELAY = DEPTH,
  parameter int CNT_W     = DEF_CNT_W,
  localparam int CW       = width_of(CHANNELS),
  localparam int DW       = width_of(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] in,
  input  logic                cfg_we,
  input  logic [CW-1:0]       cfg_ch,
  input  logic [DW-1:0]       cfg_delay,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] busy,
  output logic                cfg_err,
  output logic [CNT_W-1:0]    drop_cnt
);

  // Accumulator wide enough for the counter plus any single-edge flush sum.
  localparam int AW = ((CNT_W > 12) ? CNT_W : 12) + 1;

  logic                cfg_ok;
  logic [CHANNELS-1:0] flush;
  logic [DW-1:0]       lane_drop [CHANNELS];
  logic [AW-1:0]       flush_sum, drop_total;
  logic [CNT_W-1:0]    drop_q, drop_d;
  logic                err_q, err_d;

  assign cfg_ok = cfg_we && (int'(cfg_ch) < CHANNELS) &&
                  (cfg_delay != '0) && (int'(cfg_delay) <= DEPTH);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    assign flush[c] = cfg_ok && (int'(cfg_ch) == c);

    mitll_jtl_lane #(
      .DEPTH     (DEPTH),
      .DEF_DELAY (DEF_DELAY),
      .DW        (DW)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .in_i    (in[c]),
      .flush_i (flush[c]),
      .delay_i (cfg_delay),
      .out_o   (out[c]),
      .busy_o  (busy[c]),
      .drop_o  (lane_drop[c])
    );
  end

  // Sum discarded pulses of flushed lanes and saturate the running count.
  always_comb begin
    flush_sum = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (flush[c]) flush_sum = flush_sum + AW'(lane_drop[c]);
    end
    drop_total = AW'(drop_q) + flush_sum;
    drop_d     = (|drop_total[AW-1:CNT_W]) ? '1 : drop_total[CNT_W-1:0];
    err_d      = cfg_we && !cfg_ok;
  end

  // Status registers; reset dominates any write on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_q <= '0;
      err_q  <= 1'b0;
    end else begin
      drop_q <= drop_d;
      err_q  <= err_d;
    end
  end

  assign drop_cnt = drop_q;
  assign cfg_err  = err_q;

endmodule
